i2c_bus_cond_detect: RTL and testbench

- Front-end stage of the I2C slave. Sits directly upstream of the serial-interface FSM.
- Synchronises and deglitches raw SCL/SDA, then detects START and STOP conditions on the filtered lines.
- Drives filtered scl/sda, the 2-bit startStopDetState and the serial-interface reset (siRst) into the serial-interface FSM.

---
 rtl/i2c_bus_cond_detect_if.sv | 23 ++
 rtl/i2c_bus_cond_detect.sv | 133 +++++++++++++
 tb/tb_i2c_bus_cond_detect.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_cond_detect_if.sv
// Pad-side and detector-side signal bundle for the I2C bus condition detector.
// The pad/bench side uses master; the detector uses slave.
interface i2c_bus_cond_detect_if;
    logic       sclIn;
    logic       sdaIn;
    logic       sclFilt;
    logic       sdaFilt;
    logic [1:0] startStopDetState;
    logic       startPulse;
    logic       stopPulse;
    logic       siRst;
    logic       busTimeout;

    modport master (
        output sclIn, sdaIn,
        input  sclFilt, sdaFilt, startStopDetState, startPulse, stopPulse, siRst, busTimeout
    );

    modport slave (
        input  sclIn, sdaIn,
        output sclFilt, sdaFilt, startStopDetState, startPulse, stopPulse, siRst, busTimeout
    );
endinterface

// File: rtl/i2c_bus_cond_detect.sv
// I2C slave front end: synchronise and debounce SCL/SDA, detect START/STOP.
// Optional bus timeout on stuck-low SCL is built only when I2C_BUS_TIMEOUT_EN is defined.
module i2c_bus_cond_detect #(
    parameter int DEB_LEN     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic clk,
    input logic rst,
    i2c_bus_cond_detect_if.slave bus
);

    typedef enum logic [1:0] {
        NULL_DET  = 2'b00,
        START_DET = 2'b01,
        STOP_DET  = 2'b10
    } detState_t;

    generate
        if (DEB_LEN < 1 || DEB_LEN > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1048575) begin : gBadParam
            $error("i2c_bus_cond_detect: DEB_LEN or TIMEOUT_CYC out of range");
        end
    endgenerate

    detState_t  state, stateNxt;
    logic       sclMeta, sclSync, sdaMeta, sdaSync;
    logic       sclFilt, sdaFilt, sclPrev, sdaPrev;
    logic [7:0] sclCnt, sdaCnt;
    logic       startCond, stopCond, toHit;
    logic       startPulse, stopPulse, busTimeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclMeta <= 1'b1;
            sclSync <= 1'b1;
            sdaMeta <= 1'b1;
            sdaSync <= 1'b1;
            sclFilt <= 1'b1;
            sdaFilt <= 1'b1;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
            sclCnt  <= '0;
            sdaCnt  <= '0;
        end else begin
            sclMeta <= bus.sclIn;
            sclSync <= sclMeta;
            sdaMeta <= bus.sdaIn;
            sdaSync <= sdaMeta;
            sclPrev <= sclFilt;
            sdaPrev <= sdaFilt;

            // Filtered line follows only after DEB_LEN consecutive differing cycles
            if (sclSync == sclFilt) begin
                sclCnt <= '0;
            end else if (sclCnt == 8'(DEB_LEN - 1)) begin
                sclFilt <= sclSync;
                sclCnt  <= '0;
            end else begin
                sclCnt <= sclCnt + 8'd1;
            end

            if (sdaSync == sdaFilt) begin
                sdaCnt <= '0;
            end else if (sdaCnt == 8'(DEB_LEN - 1)) begin
                sdaFilt <= sdaSync;
                sdaCnt  <= '0;
            end else begin
                sdaCnt <= sdaCnt + 8'd1;
            end
        end
    end

    // SCL must be high in both cycles, so simultaneous SCL/SDA edges detect nothing
    assign startCond = sdaPrev & ~sdaFilt & sclPrev & sclFilt;
    assign stopCond  = ~sdaPrev & sdaFilt & sclPrev & sclFilt;

`ifdef I2C_BUS_TIMEOUT_EN
    logic [19:0] toCnt;

    // Saturating at TIMEOUT_CYC leaves exactly one pulse per low period
    assign toHit = ~sclFilt & (toCnt == 20'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            toCnt      <= '0;
            busTimeout <= 1'b0;
        end else begin
            busTimeout <= toHit;
            if (sclFilt)
                toCnt <= '0;
            else if (toCnt != 20'(TIMEOUT_CYC))
                toCnt <= toCnt + 20'd1;
        end
    end
`else
    assign toHit      = 1'b0;
    assign busTimeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NULL_DET;
            startPulse <= 1'b0;
            stopPulse  <= 1'b0;
        end else begin
            state      <= stateNxt;
            startPulse <= startCond;
            stopPulse  <= stopCond;
        end
    end

    always_comb begin
        stateNxt = state;
        if (startCond)
            stateNxt = START_DET;
        else if (stopCond)
            stateNxt = STOP_DET;
        else if (toHit)
            stateNxt = NULL_DET;
    end

    assign bus.sclFilt           = sclFilt;
    assign bus.sdaFilt           = sdaFilt;
    assign bus.startStopDetState = state;
    assign bus.startPulse        = startPulse;
    assign bus.stopPulse         = stopPulse;
    assign bus.busTimeout        = busTimeout;
`ifdef I2C_BUS_TIMEOUT_EN
    assign bus.siRst = rst | startPulse | stopPulse | busTimeout;
`else
    assign bus.siRst = rst | startPulse | stopPulse;
`endif

endmodule

// File: tb/tb_i2c_bus_cond_detect.sv
// Directed bench for i2c_bus_cond_detect: reset, debounce, START/STOP, repeated START,
// simultaneous edges, mid-frame reset and (with I2C_BUS_TIMEOUT_EN) bus timeout.
module tb_i2c_bus_cond_detect;

    localparam int Q = 125;  // quarter SCL period in clk cycles: 100 kHz bus at 50 MHz clk

    logic clk = 1'b0;
    logic rst;
    int   testCnt = 0;
    int   failCnt = 0;
    int   startSeen = 0, stopSeen = 0, siRstSeen = 0, toSeen = 0;
    int   s0, p0, r0, t0;

    i2c_bus_cond_detect_if bus ();

    i2c_bus_cond_detect #(.DEB_LEN(4), .TIMEOUT_CYC(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.startPulse === 1'b1) startSeen++;
            if (bus.stopPulse  === 1'b1) stopSeen++;
            if (bus.siRst      === 1'b1) siRstSeen++;
            if (bus.busTimeout === 1'b1) toSeen++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2cStart();
        bus.sdaIn = 1'b0; step(2 * Q);
        bus.sclIn = 1'b0; step(Q);
    endtask

    task automatic i2cBit(input logic b);
        bus.sdaIn = b;    step(Q);
        bus.sclIn = 1'b1; step(2 * Q);
        bus.sclIn = 1'b0; step(Q);
    endtask

    task automatic i2cByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) i2cBit(b[i]);
        i2cBit(1'b0);
    endtask

    task automatic i2cRepStart();
        bus.sdaIn = 1'b1; step(Q);
        bus.sclIn = 1'b1; step(Q);
        bus.sdaIn = 1'b0; step(Q);
        bus.sclIn = 1'b0; step(Q);
    endtask

    task automatic i2cStop();
        bus.sdaIn = 1'b0; step(Q);
        bus.sclIn = 1'b1; step(2 * Q);
        bus.sdaIn = 1'b1; step(2 * Q);
    endtask

    initial begin
        // Reset with both pads low: filtered lines held high
        rst = 1'b1; bus.sclIn = 1'b0; bus.sdaIn = 1'b0;
        step(3);
        check("rst_sclFilt", bus.sclFilt, 1);
        check("rst_sdaFilt", bus.sdaFilt, 1);
        check("rst_state", bus.startStopDetState, 2'b00);
        check("rst_siRst", bus.siRst, 1);
        check("rst_startPulse", bus.startPulse, 0);
        check("rst_busTimeout", bus.busTimeout, 0);
        rst = 1'b0;
        step(5);
        check("lat5_sclFilt", bus.sclFilt, 1);
        check("lat5_sdaFilt", bus.sdaFilt, 1);
        step(1);
        check("lat6_sclFilt", bus.sclFilt, 0);
        check("lat6_sdaFilt", bus.sdaFilt, 0);
        step(3);
        check("rstrel_noStart", startSeen, 0);

        // Back to idle together: no STOP since SCL moved in the same cycle
        bus.sclIn = 1'b1; bus.sdaIn = 1'b1;
        step(10);
        check("idle_sclFilt", bus.sclFilt, 1);
        check("idle_state", bus.startStopDetState, 2'b00);
        check("idle_noStop", stopSeen, 0);

        // 3-cycle SDA glitch is rejected
        s0 = startSeen;
        bus.sdaIn = 1'b0; step(3);
        bus.sdaIn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("glitch_sdaFilt", bus.sdaFilt, 1);
        end
        check("glitch_noStart", startSeen, s0);

        // 4-cycle low passes: filt falls on edge 6, startPulse on edge 7
        r0 = siRstSeen;
        bus.sdaIn = 1'b0; step(6);
        check("deb4_sdaFilt", bus.sdaFilt, 0);
        check("deb4_pulseEarly", bus.startPulse, 0);
        step(1);
        check("deb4_startPulse", bus.startPulse, 1);
        check("deb4_state", bus.startStopDetState, 2'b01);
        check("deb4_siRst", bus.siRst, 1);
        step(1);
        check("deb4_pulseEnd", bus.startPulse, 0);
        check("deb4_siRstEnd", bus.siRst, 0);
        check("deb4_startCnt", startSeen, s0 + 1);
        check("deb4_siRstCnt", siRstSeen, r0 + 1);
        p0 = stopSeen;
        bus.sdaIn = 1'b1; step(10);
        check("stop1_state", bus.startStopDetState, 2'b10);
        check("stop1_cnt", stopSeen, p0 + 1);

        // Full write frame: 0x3C+W, 0xA5
        s0 = startSeen; p0 = stopSeen; r0 = siRstSeen;
        i2cStart();
        check("frm_stateAfterStart", bus.startStopDetState, 2'b01);
        i2cByte(8'h78);
        check("frm_stateAddr", bus.startStopDetState, 2'b01);
        i2cByte(8'hA5);
        check("frm_stateData", bus.startStopDetState, 2'b01);
        check("frm_noStopYet", stopSeen, p0);
        i2cStop();
        check("frm_finalState", bus.startStopDetState, 2'b10);
        check("frm_startCnt", startSeen, s0 + 1);
        check("frm_stopCnt", stopSeen, p0 + 1);
        check("frm_siRstCnt", siRstSeen, r0 + 2);

        // Repeated START without STOP
        s0 = startSeen; p0 = stopSeen; r0 = siRstSeen;
        i2cStart();
        i2cByte(8'h79);
        i2cRepStart();
        check("rs_state", bus.startStopDetState, 2'b01);
        check("rs_startCnt", startSeen, s0 + 2);
        check("rs_siRstCnt", siRstSeen, r0 + 2);
        check("rs_noStop", stopSeen, p0);
        i2cStop();
        check("rs_stopState", bus.startStopDetState, 2'b10);

        // Simultaneous SCL/SDA edges detect nothing
        s0 = startSeen; p0 = stopSeen;
        bus.sclIn = 1'b0; bus.sdaIn = 1'b0; step(20);
        check("sim_fall_noStart", startSeen, s0);
        check("sim_fall_state", bus.startStopDetState, 2'b10);
        bus.sclIn = 1'b1; bus.sdaIn = 1'b1; step(20);
        check("sim_rise_noStop", stopSeen, p0);
        check("sim_rise_state", bus.startStopDetState, 2'b10);

        // Reset mid-transaction
        s0 = startSeen;
        bus.sdaIn = 1'b0; step(10);
        check("mr_stateBefore", bus.startStopDetState, 2'b01);
        rst = 1'b1; step(1);
        check("mr_state", bus.startStopDetState, 2'b00);
        check("mr_sdaFilt", bus.sdaFilt, 1);
        check("mr_siRst", bus.siRst, 1);
        rst = 1'b0; bus.sdaIn = 1'b1; step(10);
        check("mr_stateAfter", bus.startStopDetState, 2'b00);
        check("mr_startCnt", startSeen, s0 + 1);

        // SCL held low 200 cycles after a START
        bus.sdaIn = 1'b0; step(20);
        check("to_startState", bus.startStopDetState, 2'b01);
        t0 = toSeen; r0 = siRstSeen;
        bus.sclIn = 1'b0;
`ifdef I2C_BUS_TIMEOUT_EN
        step(105);
        check("to_early", bus.busTimeout, 0);
        step(1);
        check("to_pulse", bus.busTimeout, 1);
        check("to_state", bus.startStopDetState, 2'b00);
        check("to_siRst", bus.siRst, 1);
        step(1);
        check("to_pulseEnd", bus.busTimeout, 0);
        step(93);
        check("to_cnt", toSeen, t0 + 1);
        check("to_siRstCnt", siRstSeen, r0 + 1);
`else
        step(200);
        check("to_off_cnt", toSeen, t0);
        check("to_off_state", bus.startStopDetState, 2'b01);
        check("to_off_siRstCnt", siRstSeen, r0);
`endif
        bus.sclIn = 1'b1; bus.sdaIn = 1'b1; step(20);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
